reg_read_arbiter: RTL
=====================

Name: reg_read_arbiter

Overview:
Shares the single synchronous read port of the register file between two requesters: requester 0 is decode and requester 1 is the debug/test access unit.
Each request carries two operand addresses plus per-operand use flags. The block arbitrates round-robin and issues the two reads back-to-back on the shared port. It then returns both operands together with a one-cycle response pulse.
Unused operands and register x0 return zero without occupying the port, mirroring the read-address gating already in the datapath.

Parameters:
ADDR_W, 5, register address width
DATA_W, 32, register data width

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
Req0_Valid  input  1  requester 0 has a request
Req0_Addr_1  input  ADDR_W  requester 0 operand 1 address
Req0_Addr_2  input  ADDR_W  requester 0 operand 2 address
Req0_Use_1  input  1  requester 0 operand 1 needed
Req0_Use_2  input  1  requester 0 operand 2 needed
Req0_Ready  output  1  request 0 accepted this cycle
Req0_Resp_Valid  output  1  requester 0 data valid, 1-cycle pulse
Req0_Data_1  output  DATA_W  requester 0 operand 1
Req0_Data_2  output  DATA_W  requester 0 operand 2
Req1_*  (same nine signals for requester 1)
READ_En  output  1  register file read strobe
READ_Addr  output  ADDR_W  register file read address
READ_Data  input  DATA_W  register file read data, valid the cycle after READ_En
Busy  output  1  state != IDLE

Behaviour:
- Reset values: state IDLE; all Ready and Resp_Valid 0; all Data 0; READ_En 0; READ_Addr 0; last_grant = 1, so requester 0 wins the first tie.
- FSM states are IDLE, RD1, RD2, CAP. Each non-IDLE state lasts exactly 1 cycle: RD1 -> RD2 -> CAP -> IDLE.
- IDLE, arbitration:
  - ReqX_Ready is combinational and high only in IDLE for the granted requester.
  - With a single Valid, that requester is granted.
  - With both Valid, grant the requester != last_grant.
  - Acceptance is Valid && Ready at cycle T. On acceptance: latch owner, addresses and use flags; set last_grant = owner; go to RD1.
- Operand skip rule: op_n is read only if Use_n = 1 and Addr_n != 0. Otherwise READ_En stays 0 in that slot and the operand value is 0.
- RD1 (T+1): if op1 is read, READ_En = 1 and READ_Addr = Addr_1; otherwise READ_En = 0 and READ_Addr = 0.
- RD2 (T+2):
  - Capture op1 = READ_Data if op1 was read, else 0.
  - Drive op2 on the port using the same skip rule.
- CAP (T+3): capture op2 the same way, then return to IDLE.
- Response: at the end of CAP, update the owner's Data_1/Data_2 and set the owner's Resp_Valid. Resp_Valid is registered, high during T+4 only.
  - There is no back-pressure; the consumer must take the data in that cycle.
  - Data outputs hold their values until that requester's next response.
  - The non-owner's outputs are untouched.
- Latency is fixed at 4 cycles from accept to Resp_Valid, regardless of skips. The FSM is back in IDLE at T+4, so a new accept can coincide with the previous Resp_Valid. Throughput is 1 request per 4 cycles.
- Valid may drop at any time before acceptance with no effect. Inputs are sampled only at acceptance; later changes are ignored.
- rst mid-operation:
  - Abort immediately: next cycle is IDLE with READ_En 0.
  - No Resp_Valid is produced for the aborted request.
  - Data is cleared to 0 and last_grant returns to 1.
- READ_Addr is always 0 whenever READ_En = 0.

Test Plan:
- Reset: assert rst 2 cycles with random inputs -> all Ready, Resp_Valid, READ_En and Data are 0; Busy 0.
- Single read: regfile model returns 0x1000+addr. Req0 Addr_1=5, Addr_2=7, both uses set, accepted at T -> READ_En with addr 5 at T+1 and addr 7 at T+2. Req0_Resp_Valid pulses at T+4 with Data_1=0x1005, Data_2=0x1007.
- Skip: Req1 Addr_1=0, Use_1=1, Addr_2=9, Use_2=0 -> READ_En 0 at T+1 and T+2. Resp at T+4 with Data_1=0, Data_2=0.
- Contention: both Valid held continuously from reset -> accepts at T (req0), T+4 (req1), T+8 (req0). Each Resp_Valid goes only to its owner, and a new Ready coincides with the previous Resp_Valid.
- Abort: rst asserted during RD2 of a req0 transaction -> no Resp_Valid, READ_En 0 the next cycle. A subsequent simultaneous request grants req0.
- Hold/ignore: change Req0_Addr_1 from 5 to 3 at T+1 -> the read still uses addr 5. Req0 Data holds its value after the pulse until the next req0 response.

Source files
------------

// File: rtl/reg_read_arbiter.sv
// reg_read_arbiter
//   Shares the single synchronous register-file read port between decode
//   (requester 0) and the debug/test access unit (requester 1). A granted
//   request issues its two operand reads back-to-back (RD1, RD2), captures
//   the data and returns both operands with a one-cycle Resp_Valid pulse,
//   a fixed 4 cycles after acceptance. Operands that are unused or address
//   x0 are never put on the port and return zero.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   ReqN_Valid/Addr_1/Addr_2/
//   ReqN_Use_1/Use_2             request from requester N (N = 0, 1)
//   ReqN_Ready                   combinational accept for requester N
//   ReqN_Resp_Valid              1-cycle response pulse for requester N
//   ReqN_Data_1/Data_2           operands, held until N's next response
//   READ_En/READ_Addr/READ_Data  register file port (data one cycle later)
//   Busy                         transaction in flight
module reg_read_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Req0_Valid,
  input  logic [ADDR_W-1:0] Req0_Addr_1,
  input  logic [ADDR_W-1:0] Req0_Addr_2,
  input  logic              Req0_Use_1,
  input  logic              Req0_Use_2,
  output logic              Req0_Ready,
  output logic              Req0_Resp_Valid,
  output logic [DATA_W-1:0] Req0_Data_1,
  output logic [DATA_W-1:0] Req0_Data_2,
  input  logic              Req1_Valid,
  input  logic [ADDR_W-1:0] Req1_Addr_1,
  input  logic [ADDR_W-1:0] Req1_Addr_2,
  input  logic              Req1_Use_1,
  input  logic              Req1_Use_2,
  output logic              Req1_Ready,
  output logic              Req1_Resp_Valid,
  output logic [DATA_W-1:0] Req1_Data_1,
  output logic [DATA_W-1:0] Req1_Data_2,
  output logic              READ_En,
  output logic [ADDR_W-1:0] READ_Addr,
  input  logic [DATA_W-1:0] READ_Data,
  output logic              Busy
);

  typedef enum logic [1:0] {IDLE, RD1, RD2, CAP} state_t;

  state_t              state_q, state_d;
  logic                last_grant_q;
  logic                owner_q;
  logic [ADDR_W-1:0]   addr1_q, addr2_q;
  logic                rd1_q, rd2_q;      // operand actually goes to the port
  logic [DATA_W-1:0]   op1_q;
  logic [1:0]          resp_q;
  logic [1:0][DATA_W-1:0] data1_q, data2_q;

  logic              idle, accept, grant_id;
  logic [ADDR_W-1:0] req_addr1, req_addr2;
  logic              req_use1, req_use2;

  // Ready is suppressed while rst is high so nothing is accepted during reset.
  assign idle = (state_q == IDLE) && !rst;

  // Round-robin: on a tie the requester that did not win last goes first.
  assign Req0_Ready = idle && Req0_Valid && (!Req1_Valid ||  last_grant_q);
  assign Req1_Ready = idle && Req1_Valid && (!Req0_Valid || !last_grant_q);
  assign accept     = Req0_Ready || Req1_Ready;
  assign grant_id   = Req1_Ready;

  assign req_addr1 = grant_id ? Req1_Addr_1 : Req0_Addr_1;
  assign req_addr2 = grant_id ? Req1_Addr_2 : Req0_Addr_2;
  assign req_use1  = grant_id ? Req1_Use_1  : Req0_Use_1;
  assign req_use2  = grant_id ? Req1_Use_2  : Req0_Use_2;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RD1;
      RD1:     state_d = RD2;
      RD2:     state_d = CAP;
      CAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Port drive: address is forced to 0 whenever the strobe is low.
  always_comb begin
    READ_En   = 1'b0;
    READ_Addr = '0;
    if (state_q == RD1 && rd1_q) begin
      READ_En   = 1'b1;
      READ_Addr = addr1_q;
    end else if (state_q == RD2 && rd2_q) begin
      READ_En   = 1'b1;
      READ_Addr = addr2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      addr1_q      <= '0;
      addr2_q      <= '0;
      rd1_q        <= 1'b0;
      rd2_q        <= 1'b0;
      op1_q        <= '0;
      resp_q       <= '0;
      data1_q      <= '0;
      data2_q      <= '0;
    end else begin
      state_q <= state_d;
      resp_q  <= '0;
      if (accept) begin
        owner_q      <= grant_id;
        last_grant_q <= grant_id;
        addr1_q      <= req_addr1;
        addr2_q      <= req_addr2;
        // Skip decision made once at accept: unused or x0 never hits the port.
        rd1_q        <= req_use1 && (req_addr1 != '0);
        rd2_q        <= req_use2 && (req_addr2 != '0);
      end
      if (state_q == RD2)
        op1_q <= rd1_q ? READ_Data : '0;
      if (state_q == CAP) begin
        data1_q[owner_q] <= op1_q;
        data2_q[owner_q] <= rd2_q ? READ_Data : '0;
        resp_q[owner_q]  <= 1'b1;
      end
    end
  end

  assign Req0_Resp_Valid = resp_q[0];
  assign Req1_Resp_Valid = resp_q[1];
  assign Req0_Data_1     = data1_q[0];
  assign Req0_Data_2     = data2_q[0];
  assign Req1_Data_1     = data1_q[1];
  assign Req1_Data_2     = data2_q[1];
  assign Busy            = (state_q != IDLE);

endmodule
